// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions for the requester and the 8-bit, 16-entry slave.
//   - state_t      : requester transfer phase (IDLE, SETUP, ACCESS)
//   - APB_ADDR_W   : default address width
//   - APB_DATA_W   : default data width
//   - APB_TIMEOUT  : default ACCESS stall limit in cycles (0 = never abort)
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 8;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// ----------------------------------------------------------------------------
// apb_wait_timer
// Saturating wait-state counter. The owner clears it, then enables it once
// per stalled cycle; o_expired flags the last cycle before the limit.
//   i_pclk     : clock
//   i_presetn  : asynchronous active-low reset (count returns to 0)
//   i_clear    : synchronous clear, wins over i_enable
//   i_enable   : count this cycle
//   o_expired  : count == TIMEOUT-1 (never set when TIMEOUT == 0)
// ----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_pclk,
    input  logic i_presetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // A zero TIMEOUT still needs a legal one-bit register.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    logic [CW-1:0] r_count;

    // Counting stops at MAX so the value never wraps back to a small number.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT > 0) && (r_count == LAST);

endmodule : apb_wait_timer

// File: rtl/apb_master_err.sv
// ----------------------------------------------------------------------------
// apb_master_err
// APB requester: turns one command at a time into a SETUP/ACCESS transfer,
// returns read data and slave error, and aborts transfers that stall.
//   i_pclk, i_presetn            : clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready    : command handshake (ready only in IDLE)
//   i_cmd_write, i_cmd_addr,
//   i_cmd_wdata                  : command fields
//   o_rsp_valid                  : one-cycle response pulse
//   o_rsp_rdata, o_rsp_err,
//   o_rsp_timeout                : response fields
//   o_paddr, o_psel, o_penable,
//   o_pwrite, o_pwdata           : APB request side
//   i_prdata, i_pready, i_pslverr: APB completion side
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module apb_master_err
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              i_pclk,
    input  logic              i_presetn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;

    logic w_clear;
    logic w_enable;
    logic w_expired;

    // The timer restarts during SETUP so ACCESS always begins at zero, and
    // it only advances on cycles the slave is stalling.
    assign w_clear  = (r_state == SETUP);
    assign w_enable = (r_state == ACCESS) && !i_pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_pclk    (i_pclk),
        .i_presetn (i_presetn),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_expired (w_expired)
    );

    // Transfer FSM. pready is checked before the timeout so a slave that
    // answers on the last allowed cycle still completes normally. The
    // address/direction/data registers are left alone in IDLE.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_paddr     <= i_cmd_addr;
                        r_pwrite    <= i_cmd_write;
                        r_pwdata    <= i_cmd_wdata;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (i_pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= i_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= (!r_pwrite && !i_pslverr) ? i_prdata : '0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end else if (w_expired) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_paddr       = r_paddr;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_pwdata      = r_pwdata;

endmodule : apb_master_err

// File: tb/tb_apb_master_err.sv
// ----------------------------------------------------------------------------
// tb_apb_master_err
// Directed bench for apb_master_err (default parameters, TIMEOUT = 16).
// The bench plays both the command source and the APB slave.
// ----------------------------------------------------------------------------
module tb_apb_master_err;

    logic        pclk;
    logic        presetn;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [7:0]  cmdWdata;
    logic        rspValid;
    logic [7:0]  rspRdata;
    logic        rspErr;
    logic        rspTimeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready;
    logic        pslverr;

    int assertCount;
    int failCount;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          waits;
        logic        slverr;
        logic [7:0]  prdata;
        logic [7:0]  expRdata;
        logic        expErr;
        logic        expTimeout;
        int          expCycles;
    } vec_t;

    vec_t vecs[6];

    apb_master_err dut (
        .i_pclk        (pclk),
        .i_presetn     (presetn),
        .i_cmd_valid   (cmdValid),
        .o_cmd_ready   (cmdReady),
        .i_cmd_write   (cmdWrite),
        .i_cmd_addr    (cmdAddr),
        .i_cmd_wdata   (cmdWdata),
        .o_rsp_valid   (rspValid),
        .o_rsp_rdata   (rspRdata),
        .o_rsp_err     (rspErr),
        .o_rsp_timeout (rspTimeout),
        .o_paddr       (paddr),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_pwdata      (pwdata),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hard stop in case a wait loop is ever broken.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issue one command and act as the slave: pready rises after v.waits
    // stalled ACCESS cycles (never, if waits exceeds the timeout). While
    // stalling, pslverr is high and prdata is junk to prove they are ignored.
    task automatic applyStimulus(input vec_t v);
        int  accessCycles;
        bit  gotRsp;
        accessCycles = 0;
        gotRsp       = 0;
        @(negedge pclk);
        checkOutput("cmd_ready_idle", cmdReady, 1'b1);
        cmdValid = 1'b1;
        cmdWrite = v.write;
        cmdAddr  = v.addr;
        cmdWdata = v.wdata;
        @(posedge pclk);
        @(negedge pclk);
        cmdValid = 1'b0;
        cmdAddr  = 32'hDEAD_BEEF;
        cmdWdata = 8'hCC;
        pready   = 1'b0;
        checkOutput("setup_psel_penable", {psel, penable}, 2'b10);
        checkOutput("setup_cmd_ready", cmdReady, 1'b0);
        checkOutput("setup_paddr", paddr, v.addr);
        checkOutput("setup_pwrite", pwrite, v.write);
        if (v.write) checkOutput("setup_pwdata", pwdata, v.wdata);
        for (int c = 0; c < 40 && !gotRsp; c++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (rspValid) begin
                gotRsp = 1;
            end else begin
                accessCycles++;
                checkOutput("access_psel_penable", {psel, penable}, 2'b11);
                checkOutput("access_paddr_stable", paddr, v.addr);
                if (accessCycles > v.waits) begin
                    pready  = 1'b1;
                    pslverr = v.slverr;
                    prdata  = v.prdata;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b1;
                    prdata  = 8'hEE;
                end
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        checkOutput("rsp_seen", gotRsp, 1'b1);
        checkOutput("access_cycles", accessCycles, v.expCycles);
        checkOutput("rsp_rdata", rspRdata, v.expRdata);
        checkOutput("rsp_err", rspErr, v.expErr);
        checkOutput("rsp_timeout", rspTimeout, v.expTimeout);
        checkOutput("rsp_psel_penable", {psel, penable}, 2'b00);
        checkOutput("rsp_cmd_ready", cmdReady, 1'b1);
        @(negedge pclk);
        checkOutput("rsp_pulse_one_cycle", rspValid, 1'b0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        presetn  = 1'b0;
        cmdValid = 1'b0;
        cmdWrite = 1'b0;
        cmdAddr  = '0;
        cmdWdata = '0;
        prdata   = '0;
        pready   = 1'b0;
        pslverr  = 1'b0;

        //             wr    addr           wdata  waits slv   prdata exRd   exErr exTo  cyc
        vecs[0] = '{1'b1, 32'h0000_0003, 8'hA5, 0,   1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0000_0003, 8'h00, 2,   1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h0000_0020, 8'h00, 0,   1'b1, 8'h5A, 8'h00, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h0000_0040, 8'h00, 999, 1'b0, 8'h99, 8'h00, 1'b1, 1'b1, 16};
        vecs[4] = '{1'b1, 32'h0000_0007, 8'h3C, 1,   1'b1, 8'h66, 8'h00, 1'b1, 1'b0, 2};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 8'h00, 15,  1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0, 16};

        // Reset values while presetn is held low.
        #12;
        checkOutput("reset_cmd_ready", cmdReady, 1'b1);
        checkOutput("reset_psel_penable", {psel, penable}, 2'b00);
        checkOutput("reset_rsp", {rspValid, rspErr, rspTimeout}, 3'b000);
        checkOutput("reset_rsp_rdata", rspRdata, 8'h00);
        checkOutput("reset_paddr", paddr, 32'h0);
        checkOutput("reset_pwrite_pwdata", {pwrite, pwdata}, 9'h000);
        @(negedge pclk);
        presetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end
        checkOutput("idle_paddr_retained", paddr, 32'hFFFF_FFFF);

        // Back-to-back: cmd_valid stays high across a write then a read.
        $display("[TB] back-to-back sequence");
        @(negedge pclk);
        pready   = 1'b1;
        pslverr  = 1'b0;
        prdata   = 8'h11;
        cmdValid = 1'b1;
        cmdWrite = 1'b1;
        cmdAddr  = 32'h1;
        cmdWdata = 8'h11;
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("b2b_first_setup", {psel, penable}, 2'b10);
        cmdWrite = 1'b0;
        cmdWdata = 8'h00;
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("b2b_first_access", {psel, penable}, 2'b11);
        checkOutput("b2b_first_pwdata", pwdata, 8'h11);
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("b2b_first_rsp", {rspValid, rspErr, cmdReady}, 3'b101);
        checkOutput("b2b_idle_gap_psel", psel, 1'b0);
        checkOutput("b2b_idle_pwrite_retained", {pwrite, paddr}, {1'b1, 32'h1});
        @(posedge pclk);
        @(negedge pclk);
        cmdValid = 1'b0;
        checkOutput("b2b_second_setup", {psel, penable, pwrite}, 3'b100);
        checkOutput("b2b_second_rsp_low", rspValid, 1'b0);
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("b2b_second_access", {psel, penable}, 2'b11);
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("b2b_second_rsp", {rspValid, rspErr, rspTimeout}, 3'b100);
        checkOutput("b2b_read_data", rspRdata, 8'h11);
        pready = 1'b0;

        // Reset asserted during ACCESS drops the bus without a clock edge.
        $display("[TB] reset during ACCESS");
        @(negedge pclk);
        cmdValid = 1'b1;
        cmdWrite = 1'b0;
        cmdAddr  = 32'h9;
        @(posedge pclk);
        @(negedge pclk);
        cmdValid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        checkOutput("rst_reached_access", {psel, penable}, 2'b11);
        #1;
        presetn = 1'b0;
        #1;
        checkOutput("rst_async_bus_drop", {psel, penable}, 2'b00);
        checkOutput("rst_async_cmd_ready", cmdReady, 1'b1);
        checkOutput("rst_async_no_rsp", rspValid, 1'b0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        checkOutput("rst_release_no_rsp", rspValid, 1'b0);
        checkOutput("rst_release_idle", {cmdReady, psel}, 2'b10);
        applyStimulus('{1'b0, 32'h0000_0005, 8'h00, 1, 1'b0, 8'h4B,
                        8'h4B, 1'b0, 1'b0, 2});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule : tb_apb_master_err

// File: doc/apb_master_err.md
Name: apb_master_err

Overview:
APB requester that turns a single-entry command interface into a compliant two-phase APB transfer (SETUP, ACCESS).
- It waits on pready, then captures prdata and pslverr.
- It aborts transfers that stall too long.
- It is the initiator counterpart to the team's 8-bit, 16-entry APB slave with pslverr.
- It sits between a local controller (CPU/DMA/test sequencer) and the APB bus.

Parameters:
ADDR_W, 32, paddr / cmd_addr width
DATA_W, 8, pwdata / prdata width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  APB clock
presetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready; high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, response fields valid
rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
rsp_err  out  1  slave error or timeout
rsp_timeout  out  1  transfer aborted by timeout
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error, sampled only with pready

Behaviour:
Reset (presetn low, asynchronous):
- State is IDLE.
- All outputs are 0 except cmd_ready, which is 1.
- The wait counter is 0.
- Reset mid-transfer drops psel/penable immediately; no response is issued.

Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.

IDLE:
- cmd_ready=1, psel=0, penable=0.
- On cmd_valid at edge T: latch addr/write/wdata into paddr/pwrite/pwdata, set psel=1, go to SETUP.

SETUP:
- Exactly one cycle with psel=1, penable=0.
- Next edge: penable=1, go to ACCESS, clear the wait counter.

ACCESS:
- psel=1, penable=1; paddr/pwrite/pwdata held stable.
- Edge with pready=1:
  - Capture pslverr into rsp_err.
  - rsp_rdata = (read && !pslverr) ? prdata : 0.
  - rsp_timeout=0, rsp_valid=1 for the next cycle.
  - psel=0, penable=0, go to IDLE.
- Edge with pready=0 and counter==TIMEOUT-1 (TIMEOUT>0):
  - Abort: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - psel=0, penable=0, go to IDLE.
- Otherwise the counter increments; it saturates and never wraps.

Latency and throughput:
- Zero-wait transfer: accept at T, response valid in cycle T+2..T+3.
- cmd_ready is high again in the same cycle as rsp_valid. Back-to-back transfers therefore take 3 cycles each, and psel deasserts for exactly one cycle between them.

Signal rules:
- pslverr is ignored when pready=0.
- paddr/pwrite/pwdata retain their last value in IDLE; they do not return to 0.
- No address-range checking; error detection belongs to the slave.
- The counter is $clog2(TIMEOUT+1) bits wide.

Decomposition:
- Shared package apb_pkg:
  - state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - default APB ADDR_W/DATA_W constants, shared with the slave
- One natural sub-module: apb_wait_timer.
  - Parameterized saturating counter.
  - Inputs: clear, enable; output: expired.
  - Reused later by bus monitors.

Test Plan:
- Write 0xA5 to addr 0x3, slave pready=1 immediately -> psel high 2 cycles, penable high 1 cycle; rsp_valid one pulse, rsp_err=0, rsp_rdata=0x00.
- Read addr 0x3 with slave inserting 2 wait states, prdata=0xA5 -> ACCESS lasts 3 cycles; rsp_rdata=0xA5, rsp_err=0; paddr stable throughout.
- Read addr 0x20, slave returns pready=1, pslverr=1, prdata=0x5A -> rsp_err=1, rsp_timeout=0, rsp_rdata=0x00.
- Slave holds pready=0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then psel=0; rsp_valid with rsp_err=1, rsp_timeout=1.
- cmd_valid held high for two commands (write 0x11 to addr 1, then read addr 1) -> second SETUP starts the cycle after the first rsp_valid; one idle psel cycle between; read returns 0x11.
- Assert presetn low during ACCESS -> psel/penable drop asynchronously, no rsp_valid, cmd_ready=1 after release; a new command then completes normally.
